// File: rtl/gray_decode_monitor.sv
// Gray-to-binary decoder and sequence monitor for an N-bit Gray counter output.
// Registers each valid Gray word, decodes it, checks +1/hold steps and tracks lock.
module gray_decode_monitor #(
    parameter int N      = 5,
    parameter int ERR_W  = 8,
    parameter int RELOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gray_valid,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             wrap,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(RELOCK) + 1;
    localparam logic [GW-1:0] RELOCK_C = GW'(RELOCK);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     s1_q;
    logic             s1_v_q;
    logic [N-1:0]     ref_q, ref_d;
    logic [N-1:0]     b_new;
    logic [GW-1:0]    good_q, good_d;
    logic [ERR_W-1:0] err_d;
    logic             step_err_d, wrap_d;
    logic             is_good, is_hold;

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 1: capture the Gray word only when qualified.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= gray_valid;
            if (gray_valid) s1_q <= gray_in;
        end
    end

    assign b_new   = g2b(s1_q);
    assign is_good = (b_new == ref_q + N'(1));
    assign is_hold = (b_new == ref_q);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        ref_d      = ref_q;
        err_d      = err_count;
        step_err_d = 1'b0;
        wrap_d     = 1'b0;
        if (s1_v_q) begin
            ref_d  = b_new;
            wrap_d = is_good && (ref_q == '1) && (state_q != ST_EMPTY);
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_SYNC;
                    good_d  = GW'(1);
                end
                ST_SYNC: begin
                    if (is_good) begin
                        good_d = good_q + GW'(1);
                        if (good_q + GW'(1) == RELOCK_C) state_d = ST_LOCKED;
                    end else if (!is_hold) begin
                        good_d = GW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!is_good && !is_hold) begin
                        step_err_d = 1'b1;
                        if (err_count != '1) err_d = err_count + ERR_W'(1);
                        state_d = ST_SYNC;
                        good_d  = GW'(1);
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Stage 2: decoded value, step-check results and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            good_q    <= '0;
            ref_q     <= '0;
            err_count <= '0;
            step_err  <= 1'b0;
            wrap      <= 1'b0;
            bin_valid <= 1'b0;
            bin_out   <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            ref_q     <= ref_d;
            err_count <= err_d;
            step_err  <= step_err_d;
            wrap      <= wrap_d;
            bin_valid <= s1_v_q;
            if (s1_v_q) bin_out <= b_new;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: doc/gray_decode_monitor.md
Name: gray_decode_monitor

Overview:
Downstream consumer of the N-bit Gray counter output.
- Registers the Gray word and converts it to binary.
- Checks that each new valid sample is exactly one count above the previous one, or a hold, with wrap allowed.
- Tracks lock status, flags step errors and wrap events, and keeps a saturating error count for debug/status logic.

Parameters:
N, 5, Gray/binary word width; must match the counter's gray_out width (N >= 2).
ERR_W, 8, width of the saturating error counter.
RELOCK, 4, consecutive accepted samples (including the first) required to assert locked; range 2..2^N.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
gray_valid  input  1  qualifier; gray_in is sampled only on edges where gray_valid=1.
gray_in  input  N  Gray-coded count from the counter.
bin_out  output  N  binary equivalent of the last sampled Gray word.
bin_valid  output  1  one-cycle pulse: bin_out updated this cycle.
step_err  output  1  one-cycle pulse: illegal step detected while locked.
wrap  output  1  one-cycle pulse: accepted step from 2^N-1 to 0.
locked  output  1  level: monitor is tracking a legal sequence.
err_count  output  ERR_W  number of step errors, saturating at all-ones.

Behaviour:
- Reset, rst=0 (asynchronous, any time including mid-stream):
  - Outputs: bin_out=0, bin_valid=0, step_err=0, wrap=0, locked=0, err_count=0.
  - Internal: sample register=0, reference=0, good_cnt=0, FSM=EMPTY.
- Stage 1: on edge E with gray_valid=1, capture gray_in into s1 and set s1_v=1; otherwise s1_v=0.
- Stage 2: on edge E+1 with s1_v=1:
  - bin_out = g2b(s1), where b[N-1]=g[N-1] and b[i]=b[i+1]^g[i].
  - bin_valid=1; the checks below are evaluated in the same edge.
  - Latency from sampling edge to outputs is 1 clock. Back-to-back valid samples give back-to-back outputs, with no stall.
- Step classification, comparing new binary b against reference r (last accepted binary):
  - GOOD: b == (r+1) mod 2^N.
  - HOLD: b == r.
  - BAD: anything else.
  - r is updated to b on every stage-2 sample, whatever the class.
- FSM:
  - EMPTY:
    - First sample → SYNC with good_cnt=1.
    - No check and no error.
  - SYNC:
    - GOOD: good_cnt+1; if it reaches RELOCK → LOCKED and locked=1 on that edge.
    - HOLD: no change.
    - BAD: good_cnt=1; stays in SYNC; no step_err, err_count unchanged.
  - LOCKED:
    - GOOD/HOLD: stay.
    - BAD: step_err=1 for one cycle, err_count+1 (saturating), locked=0, → SYNC with good_cnt=1.
- wrap=1 for one cycle on any GOOD step with r=2^N-1 and b=0, in SYNC or LOCKED. Never asserted from EMPTY or on a HOLD.
- Pulse outputs (bin_valid, step_err, wrap) are 0 on every edge without a stage-2 sample. bin_out and locked hold their values.
- err_count at all-ones: a further error still pulses step_err, but the count does not change.
- good_cnt width: clog2(RELOCK)+1; it never exceeds RELOCK.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Lock-in, N=5, RELOCK=4: after reset, drive gray_valid=1 with gray 00000,00001,00011,00010,00110,00111.
   → bin_out 0,1,2,3,4,5 on consecutive cycles, each one edge after sampling.
   → locked rises on the edge showing bin_out=3; step_err never set.
2. Wrap: run the legal sequence to gray 10000 (bin 31), then 00000.
   → wrap=1 for exactly one cycle with bin_out=0; locked stays 1; err_count=0.
3. Skip error: locked at bin 7 (gray 00100), inject gray 01101 (bin 9), then bins 10,11,12.
   → step_err pulse and err_count=1 with bin_out=9; locked=0.
   → locked re-asserts on the edge showing bin_out=12.
4. Gaps and holds: while locked, hold gray_valid=0 for 3 cycles, then resend the same word twice, then continue +1.
   → bin_valid=0 during the gap; no step_err; locked stays 1.
5. Saturation, ERR_W=2: five errors, each separated by a 4-sample relock.
   → err_count goes 1,2,3,3,3; step_err pulses 5 times.
6. Async reset mid-stream: assert rst=0 between clock edges while locked at bin 20.
   → all outputs 0 immediately, before the next edge.
   → after release, the first sample is not checked (no step_err even for bin 17), and locked needs 4 samples again.
